// File: rtl/delay_seq.sv
// Sequencer for an N-stage external delay chain: it tracks which stages hold valid and last beats, and drives the shift enable, the local clear and the upstream/downstream handshakes.
// Optional DELAY_SEQ_CNT_EN adds the per-frame beat counter cnt and its sticky wrap flag ovf.
module delay_seq #(
   parameter int N  = 4,
   parameter int CW = 16
) (
   input  logic          c,
   input  logic          r,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic          s_last,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          m_last,
   output logic          e,
   output logic          rnl,
   output logic          busy
`ifdef DELAY_SEQ_CNT_EN
   ,
   output logic [CW-1:0] cnt,
   output logic          ovf
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, CLEAR} state_t;

   state_t       state, state_n;
   logic [N-1:0] vm, lm, vm_n, lm_n;
   logic         advance, s_open, e_int, acc;

   assign advance = m_ready | ~vm[N-1];
   assign s_open  = ((state == IDLE) || (state == RUN)) & advance;
   assign e_int   = (state != CLEAR) & advance;
   assign acc     = s_valid & s_open;

   // NOTE: outputs are forced to their reset values by r itself, so they are defined from the very first cycle r is high, before any edge has cleared the state.
   assign s_ready = r | s_open;
   assign e       = r | e_int;
   assign m_valid = ~r & vm[N-1];
   assign m_last  = ~r & vm[N-1] & lm[N-1];
   assign busy    = ~r & (state != IDLE);
   assign rnl     = ~r & (state != CLEAR);

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (acc) state_n = s_last ? DRAIN : RUN;
         RUN:     if (acc && s_last) state_n = DRAIN;
         DRAIN:   if (vm[N-1] && lm[N-1] && m_ready) state_n = CLEAR;
         CLEAR:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Masks move in lock-step with the external chain; index 0 takes the beat accepted this cycle.
   always_comb begin
      vm_n = vm;
      lm_n = lm;
      if (e_int) begin
         vm_n = (vm << 1) | N'(acc);
         lm_n = (lm << 1) | N'(acc & s_last);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge c) begin
      if (r) begin
         state <= IDLE;
         vm    <= '0;
         lm    <= '0;
      end else begin
         state <= state_n;
         if (state_n == CLEAR) begin
            vm <= '0;
            lm <= '0;
         end else begin
            vm <= vm_n;
            lm <= lm_n;
         end
      end
   end

`ifdef DELAY_SEQ_CNT_EN
   always_ff @(posedge c) begin
      if (r || (state_n == CLEAR)) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else if (acc) begin
         cnt <= cnt + CW'(1);
         if (&cnt) ovf <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_delay_seq.sv
// Directed bench for delay_seq: an N=4 instance driving a byte-wide model chain, and an N=1 instance for single-beat frames.
// The counter scenario is compiled only when DELAY_SEQ_CNT_EN is defined.
module tb_delay_seq;

   logic       c = 1'b0;
   logic       r, s_valid, s_last, m_ready;
   logic [7:0] s_data;
   logic       s_ready4, m_valid4, m_last4, e4, rnl4, busy4;
   logic       s_ready1, m_valid1, m_last1, e1, rnl1, busy1;
   logic [7:0] pipe4 [4];
   int         n_chk = 0;
   int         n_pass = 0;
`ifdef DELAY_SEQ_CNT_EN
   logic [2:0]  cnt4;
   logic        ovf4;
   logic [15:0] cnt1;
   logic        ovf1;
`endif

   always #5 c = ~c;

   delay_seq #(.N(4), .CW(3)) dut4 (
      .c(c), .r(r), .s_valid(s_valid), .s_ready(s_ready4), .s_last(s_last),
      .m_valid(m_valid4), .m_ready(m_ready), .m_last(m_last4),
      .e(e4), .rnl(rnl4), .busy(busy4)
`ifdef DELAY_SEQ_CNT_EN
      , .cnt(cnt4), .ovf(ovf4)
`endif
   );

   delay_seq #(.N(1)) dut1 (
      .c(c), .r(r), .s_valid(s_valid), .s_ready(s_ready1), .s_last(s_last),
      .m_valid(m_valid1), .m_ready(m_ready), .m_last(m_last1),
      .e(e1), .rnl(rnl1), .busy(busy1)
`ifdef DELAY_SEQ_CNT_EN
      , .cnt(cnt1), .ovf(ovf1)
`endif
   );

   // Data path controlled by dut4: shifts on e, cleared by rnl.
   always @(posedge c) begin
      if (!rnl4) begin
         for (int i = 0; i < 4; i++) pipe4[i] <= 8'd0;
      end else if (e4) begin
         pipe4[3] <= pipe4[2];
         pipe4[2] <= pipe4[1];
         pipe4[1] <= pipe4[0];
         pipe4[0] <= s_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic nxt();
      @(posedge c);
      #1;
   endtask

   task automatic do_reset();
      r = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0; s_data = 8'd0;
      nxt();
      nxt();
      r = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int sent, busy_cycles;
      logic acc;

      // Reset values, with m_ready low to show e and s_ready are still forced high.
      r = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0; s_data = 8'd0;
      nxt();
      nxt();
      @(negedge c);
      check("rst m_valid", m_valid4, 0);
      check("rst m_last", m_last4, 0);
      check("rst busy", busy4, 0);
      check("rst rnl", rnl4, 0);
      check("rst s_ready", s_ready4, 1);
      check("rst e", e4, 1);
      check("rst n1 m_valid", m_valid1, 0);
      check("rst n1 e", e1, 1);
`ifdef DELAY_SEQ_CNT_EN
      check("rst cnt", cnt4, 0);
      check("rst ovf", ovf4, 0);
`endif
      nxt();
      r = 1'b0;

      // Streaming: 8-beat frame, m_ready high.
      for (int t = 0; t < 14; t++) begin
         s_valid = (t < 8); s_last = (t == 7); s_data = 8'(t + 1); m_ready = 1'b1;
         @(negedge c);
         check($sformatf("stream c%0d m_valid", t), m_valid4, (t >= 4 && t <= 11));
         check($sformatf("stream c%0d m_last", t), m_last4, (t == 11));
         check($sformatf("stream c%0d busy", t), busy4, (t >= 1 && t <= 12));
         check($sformatf("stream c%0d rnl", t), rnl4, (t != 12));
         check($sformatf("stream c%0d s_ready", t), s_ready4, (t <= 7 || t == 13));
         if (t >= 4 && t <= 11) check($sformatf("stream c%0d data", t), pipe4[3], t - 3);
         nxt();
      end

      // Backpressure: m_ready low for 5 cycles while beat 2 is at the output.
      do_reset();
      sent = 0;
      for (int t = 0; t < 17; t++) begin
         s_valid = (sent < 6); s_last = (sent == 5); s_data = 8'(sent + 1);
         m_ready = !(t >= 5 && t <= 9);
         @(negedge c);
         check($sformatf("bp c%0d m_valid", t), m_valid4, (t >= 4 && t <= 14));
         check($sformatf("bp c%0d m_last", t), m_last4, (t == 14));
         check($sformatf("bp c%0d e", t), e4, !(t >= 5 && t <= 9) && t != 15);
         check($sformatf("bp c%0d s_ready", t), s_ready4, (t <= 4 || t == 10 || t == 16));
         check($sformatf("bp c%0d rnl", t), rnl4, (t != 15));
         if (t >= 4 && t <= 14)
            check($sformatf("bp c%0d data", t), pipe4[3], (t == 4) ? 1 : (t <= 10) ? 2 : t - 8);
         acc = s_valid & s_ready4;
         nxt();
         if (acc) sent++;
      end
      check("bp beats accepted", sent, 6);

      // N=1 single-beat frames: first with one stall cycle at the output, then back to back.
      do_reset();
      busy_cycles = 0;
      for (int t = 0; t < 8; t++) begin
         s_valid = (t < 7); s_last = 1'b1; m_ready = (t != 1);
         @(negedge c);
         check($sformatf("n1 c%0d m_valid", t), m_valid1, (t == 1 || t == 2 || t == 5));
         check($sformatf("n1 c%0d m_last", t), m_last1, (t == 1 || t == 2 || t == 5));
         check($sformatf("n1 c%0d busy", t), busy1, (t >= 1 && t <= 3) || t == 5 || t == 6);
         check($sformatf("n1 c%0d rnl", t), rnl1, !(t == 3 || t == 6));
         check($sformatf("n1 c%0d s_ready", t), s_ready1, (t == 0 || t == 4 || t == 7));
         if (t <= 3 && busy1) busy_cycles++;
         nxt();
      end
      check("n1 busy cycles", busy_cycles, 3);

      // Reset after three accepted beats, then a clean 2-beat frame.
      do_reset();
      for (int t = 0; t < 12; t++) begin
         r = (t == 3); m_ready = 1'b1;
         s_valid = (t <= 2 || t == 4 || t == 5); s_last = (t == 5);
         s_data = (t <= 2) ? 8'(t + 1) : 8'(t + 7);
         @(negedge c);
         check($sformatf("rmf c%0d m_valid", t), m_valid4, (t == 8 || t == 9));
         check($sformatf("rmf c%0d m_last", t), m_last4, (t == 9));
         check($sformatf("rmf c%0d rnl", t), rnl4, !(t == 3 || t == 10));
         check($sformatf("rmf c%0d busy", t), busy4, (t == 1 || t == 2 || (t >= 5 && t <= 10)));
         if (t == 3) check("rmf in reset e", e4, 1);
         if (t == 4) check("rmf vm empty", dut4.vm, 0);
         if (t == 8 || t == 9) check($sformatf("rmf c%0d data", t), pipe4[3], t + 3);
         nxt();
      end

`ifdef DELAY_SEQ_CNT_EN
      // 10-beat frame with a 3-bit counter: wraps once, ends at 2, cleared by CLEAR.
      do_reset();
      for (int t = 0; t < 15; t++) begin
         s_valid = (t < 10); s_last = (t == 9); m_ready = 1'b1;
         @(negedge c);
         check($sformatf("cnt c%0d cnt", t), cnt4, (t <= 10) ? t % 8 : (t <= 13) ? 2 : 0);
         check($sformatf("cnt c%0d ovf", t), ovf4, (t >= 8 && t <= 13));
         check($sformatf("cnt c%0d m_last", t), m_last4, (t == 13));
         nxt();
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
